// File: rtl/and_sweep_checker_pkg.sv
// Shared definitions for the AND sweep checker: FSM encodings and default sizing.
package and_sweep_defs;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int N_DEF    = 2;
   localparam int HOLD_DEF = 5;

endpackage

// File: rtl/and_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker (master) and its environment (slave).
// The first_fail signal exists only when AND_SWEEP_FIRSTFAIL_EN is defined.
interface and_sweep_checker_if #(parameter int N = 2);
   logic         start;
   logic         c_in;
   logic [N-1:0] a_out;
   logic         busy;
   logic         done;
   logic         pass;
   logic [N:0]   err_count;
`ifdef AND_SWEEP_FIRSTFAIL_EN
   logic [N-1:0] first_fail;

   modport master (input start, c_in, output a_out, busy, done, pass, err_count, first_fail);
   modport slave  (output start, c_in, input a_out, busy, done, pass, err_count, first_fail);
`else
   modport master (input start, c_in, output a_out, busy, done, pass, err_count);
   modport slave  (output start, c_in, input a_out, busy, done, pass, err_count);
`endif
endinterface

// File: rtl/and_sweep_checker_hold_ctr.sv
// Modulo-HOLD up-counter; tc_o flags the last held cycle of the current vector.
module sweep_hold_ctr #(
   parameter int HOLD = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam int             W    = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [W-1:0]   LAST = W'(HOLD - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc_o = en_i && (cnt_q == LAST);

   // next count: clear wins, otherwise wrap at LAST while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
   end

   // count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/and_sweep_checker.sv
// Self-running exhaustive sweep of an N-input AND gate: drives every vector for
// HOLD cycles, samples c_in on the last held cycle and counts mismatches.
// Optional first-failing-vector capture: AND_SWEEP_FIRSTFAIL_EN.
//
// state   | meaning
// IDLE    | waiting for start, a_out parked at 0
// RUN     | sweeping vectors, busy high
// DONE    | results valid, done high until next start
module and_sweep_checker
   import and_sweep_defs::*;
#(
   parameter int N    = N_DEF,
   parameter int HOLD = HOLD_DEF
) (
   input logic                   clk,
   input logic                   rst,
   and_sweep_checker_if.master   bus
);
   logic [1:0]   state_q, state_d;
   logic [N-1:0] vec_q, vec_d;
   logic [N:0]   err_q, err_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         hold_tc;
   logic         mismatch;
`ifdef AND_SWEEP_FIRSTFAIL_EN
   logic [N-1:0] ff_q, ff_d;
`endif

   sweep_hold_ctr #(.HOLD(HOLD)) u_hold (
      .clk   (clk),
      .rst   (rst),
      .clr_i (state_q != ST_RUN),
      .en_i  (state_q == ST_RUN),
      .tc_o  (hold_tc)
   );

   // expected response is 1 only for the all-ones vector
   assign mismatch = bus.c_in != (&vec_q);

   // FSM, vector stepping and error accumulation
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      err_d   = err_q;
      busy_d  = busy_q;
      done_d  = done_q;
`ifdef AND_SWEEP_FIRSTFAIL_EN
      ff_d    = ff_q;
`endif
      case (state_q)
         ST_RUN: begin
            if (hold_tc) begin
               err_d = err_q + (N+1)'(mismatch);
`ifdef AND_SWEEP_FIRSTFAIL_EN
               if (mismatch && (err_q == '0))
                  ff_d = vec_q;
`endif
               // all-ones + 1 wraps to 0, which also parks a_out for DONE
               vec_d = vec_q + N'(1);
               if (&vec_q) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            if (bus.start) begin
               state_d = ST_RUN;
               vec_d   = '0;
               err_d   = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
`ifdef AND_SWEEP_FIRSTFAIL_EN
               ff_d    = '0;
`endif
            end
         end
      endcase
   end

   // state and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef AND_SWEEP_FIRSTFAIL_EN
         ff_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef AND_SWEEP_FIRSTFAIL_EN
         ff_q    <= ff_d;
`endif
      end
   end

   assign bus.a_out     = vec_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err_count = err_q;
   assign bus.pass      = (state_q == ST_DONE) && (err_q == '0);
`ifdef AND_SWEEP_FIRSTFAIL_EN
   assign bus.first_fail = ff_q;
`endif
endmodule

// File: tb/tb_and_sweep_checker.sv
// Directed bench for and_sweep_checker: an N=2/HOLD=5 instance with a selectable
// fake gate on c_in, and an N=3/HOLD=1 instance with a correct AND gate.
module tb_and_sweep_checker;
   localparam int N_A    = 2;
   localparam int HOLD_A = 5;
   localparam int LEN_A  = (1 << N_A) * HOLD_A;
   localparam int N_B    = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   c_mode = 0;   // 0: c_in = &a_out, 1: tied 0, 2: tied 1
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   and_sweep_checker_if #(.N(N_A)) ia ();
   and_sweep_checker_if #(.N(N_B)) ib ();

   assign ia.c_in = (c_mode == 0) ? (&ia.a_out) : (c_mode == 2);
   assign ib.c_in = &ib.a_out;

   and_sweep_checker #(.N(N_A), .HOLD(HOLD_A)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   and_sweep_checker #(.N(N_B), .HOLD(1))      dut_b (.clk(clk), .rst(rst), .bus(ib));

   typedef struct {
      string      name;
      int         mode;
      int         exp_err;
      bit         exp_pass;
      logic [1:0] exp_ff;
   } vec_t;

   vec_t tbl[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge: pulses start, then counts cycles until done.
   // Cycles p1/p2 re-assert start during RUN. a_out/busy are checked every RUN cycle.
   task automatic sweep_a(input int p1, input int p2, output int done_cyc, output int bad_cyc);
      ia.start = 1'b1;
      done_cyc = -1;
      bad_cyc  = 0;
      for (int cyc = 1; cyc <= LEN_A + 20; cyc++) begin
         @(negedge clk);
         ia.start = (cyc == p1 || cyc == p2);
         if (ia.done) begin
            ia.start = 1'b0;
            done_cyc = cyc;
            break;
         end
         if (ia.a_out !== N_A'((cyc - 1) / HOLD_A) || ia.busy !== 1'b1)
            bad_cyc++;
      end
      ia.start = 1'b0;
   endtask

   initial begin
      int dc, bad;
      tbl[0] = '{"and_gate", 0, 0, 1'b1, 2'b00};
      tbl[1] = '{"tied0",    1, 1, 1'b0, 2'b11};
      tbl[2] = '{"tied1",    2, 3, 1'b0, 2'b00};

      ia.start = 1'b0;
      ib.start = 1'b0;
      #1;
      chk("rst_busy",  32'(ia.busy), 0);
      chk("rst_done",  32'(ia.done), 0);
      chk("rst_pass",  32'(ia.pass), 0);
      chk("rst_err",   32'(ia.err_count), 0);
      chk("rst_a_out", 32'(ia.a_out), 0);
`ifdef AND_SWEEP_FIRSTFAIL_EN
      chk("rst_ff",    32'(ia.first_fail), 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("idle_busy", 32'(ia.busy), 0);

      // table-driven full sweeps
      foreach (tbl[i]) begin
         c_mode = tbl[i].mode;
         sweep_a(0, 0, dc, bad);
         chk({tbl[i].name, "_done_cycle"}, 32'(dc), LEN_A + 1);
         chk({tbl[i].name, "_run_cycles"}, 32'(bad), 0);
         chk({tbl[i].name, "_err"},        32'(ia.err_count), 32'(tbl[i].exp_err));
         chk({tbl[i].name, "_pass"},       32'(ia.pass), 32'(tbl[i].exp_pass));
         chk({tbl[i].name, "_busy_low"},   32'(ia.busy), 0);
         chk({tbl[i].name, "_a_out_zero"}, 32'(ia.a_out), 0);
`ifdef AND_SWEEP_FIRSTFAIL_EN
         chk({tbl[i].name, "_first_fail"}, 32'(ia.first_fail), 32'(tbl[i].exp_ff));
`endif
         @(negedge clk);
         chk({tbl[i].name, "_done_holds"}, 32'(ia.done), 1);
      end

      // reset in the middle of a sweep: vector 0 already counted as a mismatch
      c_mode = 2;
      ia.start = 1'b1;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         @(negedge clk);
         ia.start = 1'b0;
      end
      chk("pre_rst_err", 32'(ia.err_count), 1);
      rst = 1'b1;
      #1;
      chk("midrst_busy",  32'(ia.busy), 0);
      chk("midrst_a_out", 32'(ia.a_out), 0);
      chk("midrst_err",   32'(ia.err_count), 0);
      chk("midrst_done",  32'(ia.done), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_idle_busy", 32'(ia.busy), 0);
      chk("post_rst_idle_done", 32'(ia.done), 0);

      // start re-pulsed during RUN is ignored
      c_mode = 2;
      sweep_a(3, 10, dc, bad);
      chk("repulse_done_cycle", 32'(dc), LEN_A + 1);
      chk("repulse_run_cycles", 32'(bad), 0);
      chk("repulse_err",        32'(ia.err_count), 3);

      // start in DONE begins a fresh sweep with counters cleared
      c_mode = 0;
      ia.start = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
      chk("restart_busy", 32'(ia.busy), 1);
      chk("restart_err_cleared", 32'(ia.err_count), 0);
      chk("restart_done_low", 32'(ia.done), 0);
`ifdef AND_SWEEP_FIRSTFAIL_EN
      chk("restart_ff_cleared", 32'(ia.first_fail), 0);
`endif
      dc = -1;
      for (int cyc = 2; cyc <= LEN_A + 20; cyc++) begin
         @(negedge clk);
         if (ia.done) begin dc = cyc; break; end
      end
      chk("restart_done_cycle", 32'(dc), LEN_A + 1);
      chk("restart_pass", 32'(ia.pass), 1);

      // start held high: done lasts exactly one cycle before the next sweep
      ia.start = 1'b1;
      dc = -1;
      for (int cyc = 1; cyc <= LEN_A + 20; cyc++) begin
         @(negedge clk);
         if (ia.done) begin dc = cyc; break; end
      end
      chk("held_done_cycle", 32'(dc), LEN_A + 1);
      @(negedge clk);
      chk("held_done_one_cycle", 32'(ia.done), 0);
      chk("held_rerun_busy", 32'(ia.busy), 1);
      ia.start = 1'b0;

      // N=3, HOLD=1: a new vector every cycle
      ib.start = 1'b1;
      bad = 0;
      dc = -1;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(negedge clk);
         ib.start = 1'b0;
         if (ib.done) begin dc = cyc; break; end
         if (ib.a_out !== N_B'(cyc - 1) || ib.busy !== 1'b1) bad++;
      end
      chk("n3_done_cycle", 32'(dc), 9);
      chk("n3_step_cycles", 32'(bad), 0);
      chk("n3_pass", 32'(ib.pass), 1);
      chk("n3_err", 32'(ib.err_count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/and_sweep_checker.md
# and_sweep_checker

Self-running stimulus/response stage for the two-input gate blocks. It drives every input combination of an N-input AND-type gate onto `a_out` and holds each vector for HOLD cycles. It samples the gate's output on `c_in` and compares it with the expected AND of the vector, then reports error count and pass/fail. It sits directly upstream of the gate, driving its inputs, and directly downstream of it, consuming its output. This replaces hand-written `#delay` stimulus with a synthesizable, clocked sweep.

## Interface
- N, 2, number of gate inputs (≥1)
- HOLD, 5, cycles each vector is held (≥1); sample taken on last held cycle
- clk  in  1  system clock, rising-edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- start  in  1  begin sweep; honoured only in IDLE or DONE
- c_in  in  1  gate output under test (combinational from a_out)
- a_out  out  N  current input vector to gate
- busy  out  1  high while sweep in progress
- done  out  1  high in DONE until next start or reset
- pass  out  1  high in DONE iff err_count==0
- err_count  out  N+1  number of mismatching vectors, 0..2^N
- first_fail  out  N  first mismatching vector (only with AND_SWEEP_FIRSTFAIL_EN)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: a_out=0, busy=0. start=1 → RUN; vec=0, hold_cnt=0, err_count=0.
- RUN: busy=1. a_out=vec. hold_cnt increments each cycle.
  - When hold_cnt==HOLD-1, compare c_in with &vec and increment err_count on mismatch.
  - In the same cycle, hold_cnt→0 and vec→vec+1.
  - If vec was all-ones, → DONE instead.
- DONE: busy=0, done=1, pass=(err_count==0). a_out returns to 0. err_count holds its value.
  - start=1 → RUN with counters cleared as from IDLE.
- start during RUN is ignored.
- err_count cannot overflow: at most 2^N mismatches, width N+1.
- Expected value is strictly AND: 1 only for the all-ones vector.

## Timing
- Reset (async assert, any state): state=IDLE, a_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0.
  - Takes effect immediately; mid-sweep results are discarded.
- Cycle 0 = cycle start is sampled high in IDLE/DONE. From cycle 1, busy=1 and a_out=0.
- Vector k is driven during cycles 1+k·HOLD .. (k+1)·HOLD and sampled on the last of these.
- done/pass rise at cycle 2^N·HOLD+1; busy falls on the same cycle.
- Total sweep latency from start to done is 2^N·HOLD+1 cycles.
- HOLD=1: a new vector every cycle, each sampled in the cycle it is driven.
- start held high continuously: the sweep re-runs immediately after each DONE cycle. done is high for exactly one cycle in that case.
- Outputs are registered except pass. pass is combinational from state and err_count.

## Configuration
- AND_SWEEP_FIRSTFAIL_EN defined: the first_fail port exists.
  - It captures vec on the first mismatch of a sweep and ignores later mismatches.
  - It is cleared on start and on reset.
  - It is meaningful only when done=1 and pass=0.
- Not defined: no first_fail port or register; all other behaviour is identical.

## Structure
- Shared package/include and_sweep_defs:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - default N and HOLD values.
- One sub-module, sweep_hold_ctr:
  - parameterised modulo-HOLD counter with clear and a terminal-count output.
  - The FSM, vector register and comparator stay in the top.

## Test plan
- c_in tied to &a_out, N=2, HOLD=5, start pulse → busy for 20 cycles, then done=1, pass=1, err_count=0 at cycle 21.
- c_in tied 0 → err_count=1, pass=0; with macro, first_fail=2'b11.
- c_in tied 1 → err_count=3; with macro, first_fail=2'b00.
- rst asserted at cycle 7 of a sweep → immediately busy=0, a_out=0, err_count=0. After release, the block sits in IDLE until start.
- start re-pulsed at cycles 3 and 10 during RUN → ignored, done still at cycle 21. start pulsed in DONE → new sweep, err_count cleared.
- N=3, HOLD=1, c_in=&a_out → a_out steps 0..7 on consecutive cycles, done at cycle 9, pass=1.
